// File: rtl/vga_fb_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_reader_pkg
// Brief    : Shared display / frame-buffer geometry and read-FSM encoding.
// Revision : 1.0
// ============================================================================
package vga_fb_reader_pkg;

    localparam int CNT_W    = 11;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int IMG_W    = 320;
    localparam int IMG_H    = 240;
    localparam int ADDR_W   = 17;
    localparam int PIX_W    = 12;

    typedef enum logic [1:0] {
        S_VBLANK = 2'd0,
        S_ACTIVE = 2'd1,
        S_SWAP   = 2'd2
    } rd_state_e;

    // Horizontal pixel doubling: two display columns share one stored column.
    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [ADDR_W-1:0] base,
        input logic [CNT_W-1:0]  h
    );
        return base + ADDR_W'(h[CNT_W-1:1]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_fb_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_reader_if
// Brief    : Frame-buffer read port plus the buffer-swap handshake.
// Revision : 1.0
// ============================================================================
interface vga_fb_reader_if;
    import vga_fb_reader_pkg::*;

    logic [ADDR_W-1:0] fb_rd_addr;
    logic              fb_rd_sel;
    logic [PIX_W-1:0]  fb_rd_data;
    logic              swap_req;
    logic              swap_ack;

    modport master (
        output fb_rd_addr,
        output fb_rd_sel,
        output swap_ack,
        input  fb_rd_data,
        input  swap_req
    );

    modport slave (
        input  fb_rd_addr,
        input  fb_rd_sel,
        input  swap_ack,
        output fb_rd_data,
        output swap_req
    );

endinterface
`default_nettype wire

// File: rtl/vga_pix_delay.sv
`default_nettype none
// ============================================================================
// Module   : vga_pix_delay
// Brief    : Resettable shift-register delay line for per-pixel side flags.
// Revision : 1.0
// ============================================================================
module vga_pix_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  wire logic             CLK25,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] shift_q;
    logic [DEPTH-1:0][WIDTH-1:0] shift_d;

    always_comb begin
        shift_d    = shift_q;
        shift_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            shift_d[i] = shift_q[i-1];
        end
    end

    always_ff @(posedge CLK25) begin
        if (reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign dout = shift_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_fb_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_reader
// Brief    : 2x pixel-doubled frame-buffer read sequencer with buffer swap.
// Revision : 1.0
// ============================================================================
module vga_fb_reader
    import vga_fb_reader_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  wire logic             CLK25,
    input  wire logic             reset,
    input  wire logic [CNT_W-1:0] hcnt,
    input  wire logic [CNT_W-1:0] vcnt,
    vga_fb_reader_if.master       fb,
    output logic      [PIX_W-1:0] rgb_out,
    output logic                  de_out,
    output logic                  frame_start
);

    localparam int                DLY_DEPTH = 1 + RD_LAT;
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sel_q, sel_d;
    logic              ack_q, ack_d;
    logic              pending_q, pending_d;
    logic              swapped_q, swapped_d;
    logic [PIX_W-1:0]  rgb_q, rgb_d;
    logic              de_q, de_d;
    logic              fs_q, fs_d;

    logic              in_view;
    logic              frame_origin;
    logic              frame_end;
    logic              vis_run;
    logic [ADDR_W-1:0] cur_base;
    logic [1:0]        dly_in;
    logic [1:0]        dly_out;

    assign in_view      = (hcnt < CNT_W'(H_ACTIVE)) && (vcnt < CNT_W'(V_ACTIVE));
    assign frame_origin = (hcnt == '0) && (vcnt == '0);
    assign frame_end    = (hcnt == '0) && (vcnt == CNT_W'(V_ACTIVE));

    // After a reset nothing is shown until the counters pass the frame origin.
    assign vis_run  = in_view && ((state_q == S_ACTIVE) || frame_origin);
    assign cur_base = frame_origin ? '0 : line_base_q;

    // ------------------------------------------------------------------
    // Read-side FSM and swap handshake
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ack_d     = 1'b0;
        swapped_d = swapped_q;
        pending_d = pending_q | (fb.swap_req & ~ack_q);

        case (state_q)
            S_ACTIVE: begin
                if (frame_end) begin
                    state_d = S_VBLANK;
                end
            end
            S_VBLANK: begin
                if (frame_origin) begin
                    state_d   = S_ACTIVE;
                    swapped_d = 1'b0;
                end else if (pending_q && !swapped_q && !in_view) begin
                    // Output registers show the swap during the S_SWAP cycle.
                    state_d   = S_SWAP;
                    sel_d     = ~sel_q;
                    ack_d     = 1'b1;
                    pending_d = 1'b0;
                    swapped_d = 1'b1;
                end
            end
            S_SWAP: begin
                if (frame_origin) begin
                    state_d   = S_ACTIVE;
                    swapped_d = 1'b0;
                end else begin
                    state_d   = S_VBLANK;
                end
            end
            default: begin
                state_d = S_VBLANK;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address generation and output alignment
    // ------------------------------------------------------------------
    always_comb begin
        line_base_d = line_base_q;
        addr_d      = addr_q;

        if (vis_run) begin
            addr_d = pix_addr(cur_base, hcnt);
        end

        // Advance the stored row only after odd display lines (vertical doubling).
        if (frame_origin) begin
            line_base_d = '0;
        end else if ((state_q == S_ACTIVE) && in_view &&
                     (hcnt == CNT_W'(H_ACTIVE - 1)) && vcnt[0]) begin
            line_base_d = line_base_q + LINE_STEP;
        end

        de_d  = dly_out[0];
        fs_d  = dly_out[1];
        rgb_d = dly_out[0] ? fb.fb_rd_data : '0;
    end

    assign dly_in = {vis_run && frame_origin, vis_run};

    vga_pix_delay #(
        .DEPTH (DLY_DEPTH),
        .WIDTH (2)
    ) u_pix_delay (
        .CLK25 (CLK25),
        .reset (reset),
        .din   (dly_in),
        .dout  (dly_out)
    );

    always_ff @(posedge CLK25) begin
        if (reset) begin
            state_q     <= S_VBLANK;
            line_base_q <= '0;
            addr_q      <= '0;
            sel_q       <= 1'b0;
            ack_q       <= 1'b0;
            pending_q   <= 1'b0;
            swapped_q   <= 1'b0;
            rgb_q       <= '0;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_base_q <= line_base_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            ack_q       <= ack_d;
            pending_q   <= pending_d;
            swapped_q   <= swapped_d;
            rgb_q       <= rgb_d;
            de_q        <= de_d;
            fs_q        <= fs_d;
        end
    end

    assign fb.fb_rd_addr = addr_q;
    assign fb.fb_rd_sel  = sel_q;
    assign fb.swap_ack   = ack_q;
    assign rgb_out       = rgb_q;
    assign de_out        = de_q;
    assign frame_start   = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_reader
// Brief    : Self-checking bench: compressed counter sweeps, BRAM model, swaps.
// Revision : 1.0
// ============================================================================
module tb_vga_fb_reader;
    import vga_fb_reader_pkg::*;

    localparam int RD_LAT = 1;
    localparam int PIPE   = 2 + RD_LAT;

    typedef struct packed {
        logic             de;
        logic [PIX_W-1:0] rgb;
        logic             fs;
    } exp_t;

    logic             CLK25 = 1'b0;
    logic             reset = 1'b0;
    logic [CNT_W-1:0] hcnt  = '0;
    logic [CNT_W-1:0] vcnt  = '0;
    logic [PIX_W-1:0] rgb_out;
    logic             de_out;
    logic             frame_start;

    vga_fb_reader_if fb();

    vga_fb_reader #(
        .RD_LAT (RD_LAT)
    ) dut (
        .CLK25       (CLK25),
        .reset       (reset),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .fb          (fb),
        .rgb_out     (rgb_out),
        .de_out      (de_out),
        .frame_start (frame_start)
    );

    always #20 CLK25 = ~CLK25;

    // Stored image: each buffer holds a distinct pattern derived from the address.
    function automatic logic [PIX_W-1:0] bram_word(input logic sel, input logic [ADDR_W-1:0] a);
        return a[PIX_W-1:0] ^ (sel ? 12'hA5A : 12'h000);
    endfunction

    logic [PIX_W-1:0] bram_pipe [RD_LAT];
    always @(posedge CLK25) begin
        bram_pipe[0] <= bram_word(fb.fb_rd_sel, fb.fb_rd_addr);
        for (int i = 1; i < RD_LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign fb.fb_rd_data = bram_pipe[RD_LAT-1];

    int               n_tests = 0;
    int               n_fail  = 0;
    logic             exp_sel = 1'b0;
    bit               running = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    exp_t             q[$];

    int   bl_toggles, bl_acks, bl_first;
    logic bl_prev;
    bit   bl_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One pixel clock with counters (h, v); checks address now and pixel outputs PIPE steps later.
    task automatic step(input int h, input int v);
        exp_t e;
        bit   vis;
        int   row, col;
        hcnt = CNT_W'(h);
        vcnt = CNT_W'(v);
        if (h == 0 && v == 0) running = 1'b1;
        vis  = running && (h < H_ACTIVE) && (v < V_ACTIVE);
        row  = v / 2;
        col  = h / 2;
        if (vis) exp_addr = ADDR_W'(row * IMG_W + col);
        e.de  = vis;
        e.rgb = vis ? bram_word(exp_sel, ADDR_W'(row * IMG_W + col)) : '0;
        e.fs  = vis && (h == 0) && (v == 0);
        q.push_back(e);
        @(posedge CLK25);
        #1;
        check("fb_rd_addr", 32'(fb.fb_rd_addr), 32'(exp_addr));
        if (vis) begin
            check("sel_in_active", 32'(fb.fb_rd_sel), 32'(exp_sel));
            check("ack_in_active", 32'(fb.swap_ack), 32'd0);
        end
        if (q.size() == PIPE) begin
            e = q.pop_front();
            check("de_out", 32'(de_out), 32'(e.de));
            check("rgb_out", 32'(rgb_out), 32'(e.rgb));
            check("frame_start", 32'(frame_start), 32'(e.fs));
        end
    endtask

    task automatic reset_step(input int h, input int v);
        exp_t z;
        reset = 1'b1;
        hcnt  = CNT_W'(h);
        vcnt  = CNT_W'(v);
        @(posedge CLK25);
        #1;
        reset = 1'b0;
        check("rst_addr", 32'(fb.fb_rd_addr), 32'd0);
        check("rst_sel", 32'(fb.fb_rd_sel), 32'd0);
        check("rst_ack", 32'(fb.swap_ack), 32'd0);
        check("rst_rgb", 32'(rgb_out), 32'd0);
        check("rst_de", 32'(de_out), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        running  = 1'b0;
        exp_addr = '0;
        exp_sel  = 1'b0;
        z        = '0;
        q.delete();
        for (int i = 0; i < PIPE - 1; i++) q.push_back(z);
    endtask

    task automatic blank_step(input int k, input int h, input int v);
        step(h, v);
        if (fb.fb_rd_sel !== bl_prev) begin
            bl_toggles++;
            if (bl_first < 0) bl_first = k;
        end
        bl_prev = fb.fb_rd_sel;
        if (fb.swap_ack === 1'b1) begin
            bl_acks++;
            if (!bl_hold) fb.swap_req = 1'b0;
        end
    endtask

    // Vertical blanking: at most one swap, only if a request is outstanding.
    task automatic blank(input bit hold, input bit req_now);
        bit expect_swap;
        if (req_now) fb.swap_req = 1'b1;
        expect_swap = fb.swap_req;
        bl_hold    = hold;
        bl_toggles = 0;
        bl_acks    = 0;
        bl_first   = -1;
        bl_prev    = fb.fb_rd_sel;
        for (int k = 0; k <= 12; k++) blank_step(k, k, V_ACTIVE);
        for (int i = 0; i < 6; i++)
            blank_step(20 + i, int'($urandom_range(0, 799)), V_ACTIVE + 1 + i * 7);
        blank_step(40, 799, 524);
        check("swap_count", 32'(bl_toggles), 32'(expect_swap));
        check("ack_pulses", 32'(bl_acks), 32'(expect_swap));
        if (expect_swap) check("swap_within_2", 32'(bl_first >= 1 && bl_first <= 2), 32'd1);
        exp_sel = exp_sel ^ expect_swap;
        check("sel_after_blank", 32'(fb.fb_rd_sel), 32'(exp_sel));
    endtask

    task automatic frame(input int req_line, input int rst_line, input int n_full);
        for (int v = 0; v < V_ACTIVE; v++) begin
            if (v == req_line) fb.swap_req = 1'b1;
            if (v < n_full) begin
                for (int h = 0; h < 800; h++) step(h, v);
            end else begin
                if (v == 0) step(0, 0);
                if (v == 3) step(5, 3);
                if (v == rst_line) begin
                    step(int'($urandom_range(6, 299)), v);
                    reset_step(300, v);
                end else begin
                    step(int'($urandom_range(6, 638)), v);
                end
                step(H_ACTIVE - 1, v);
                step(int'($urandom_range(H_ACTIVE, 799)), v);
            end
        end
    endtask

    initial begin
        fb.swap_req = 1'b0;
        for (int i = 0; i < RD_LAT; i++) bram_pipe[i] = '0;
        reset_step(0, 0);

        frame(-1, -1, 2);                               blank(1'b0, 1'b0);
        frame(100, -1, 0);                              blank(1'b0, 1'b0);
        frame(int'($urandom_range(1, 470)), -1, 0);     blank(1'b1, 1'b0);
        frame(-1, -1, 0);                               blank(1'b0, 1'b0);
        frame(-1, -1, 0);                               blank(1'b0, 1'b1);
        frame(int'($urandom_range(1, 470)), -1, 0);     blank(1'b0, 1'b0);
        frame(-1, 200, 0);                              blank(1'b0, 1'b0);
        frame(-1, -1, 1);                               blank(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
- Read-side sequencer for the camera frame buffer.
- Consumes the pixel counters from the VGA timing generator (hcnt 0..799, vcnt 0..524, 640x480 active).
- Issues frame-buffer BRAM read addresses for a 320x240 image, pixel-doubled 2x in both axes.
- Re-aligns the returned pixel with a display-enable, and owns the double-buffer swap handshake with the camera capture side.
- Sits between the VGA timing generator, the dual-buffer frame RAM and the RGB output pins.

Parameters:
- IMG_W, 320, stored image width in pixels.
- IMG_H, 240, stored image height in lines.
- ADDR_W, 17, frame-buffer address width per buffer.
- PIX_W, 12, pixel width (RGB444).
- H_ACTIVE, 640, visible columns.
- V_ACTIVE, 480, visible lines.
- RD_LAT, 1, BRAM read latency in cycles (1 or 2 supported).

Ports:
- CLK25  in  1  pixel clock, 25 MHz.
- reset  in  1  synchronous, active-high.
- hcnt  in  11  horizontal counter from timing generator.
- vcnt  in  11  vertical counter from timing generator.
- fb_rd_addr  out  ADDR_W  read address into the selected buffer.
- fb_rd_sel  out  1  buffer currently displayed (0/1).
- fb_rd_data  in  PIX_W  BRAM read data, valid RD_LAT cycles after address.
- swap_req  in  1  capture: a completed frame is ready in buffer ~fb_rd_sel; held high until acked.
- swap_ack  out  1  one-cycle pulse: swap performed.
- rgb_out  out  PIX_W  pixel to DAC/pins.
- de_out  out  1  display enable, aligned with rgb_out.
- frame_start  out  1  one-cycle pulse at first visible pixel of a frame.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock CLK25.
- Reset values: fb_rd_addr=0, fb_rd_sel=0, swap_ack=0, rgb_out=0, de_out=0, frame_start=0, line_base=0, swap_pending=0, state=S_VBLANK.
- Reset mid-frame aborts everything immediately. Nothing resumes until the next vcnt==0,hcnt==0.
- Visible is decoded from the counters: hcnt<H_ACTIVE && vcnt<V_ACTIVE. The activeArea input is not used.
- Address: fb_rd_addr registered as line_base + hcnt[10:1] while visible. It holds its last value otherwise. Latency is 1 cycle after the counter value.
- line_base update:
  - Cleared at vcnt==0,hcnt==0.
  - At hcnt==H_ACTIVE-1 on a visible line with vcnt[0]==1, line_base += IMG_W.
  - Therefore lines 2k and 2k+1 read the same row.
  - Last row base = 239*320 = 76480. Max address = 76799.
- Pipeline: visible flag is delayed 1+RD_LAT cycles to form de_out. rgb_out = fb_rd_data when the delayed flag is set, else 0. Total counter-to-pixel latency is 1+RD_LAT+1 register stage.
- frame_start: pulses on the cycle de_out first rises in a frame.
- FSM states:
  - S_ACTIVE: visible lines. Goes to S_VBLANK at vcnt==V_ACTIVE,hcnt==0.
  - S_VBLANK: if swap_pending on entry cycle or at any cycle in blanking, go to S_SWAP. Go to S_ACTIVE at vcnt==0,hcnt==0.
  - S_SWAP: single cycle. Toggles fb_rd_sel, pulses swap_ack, clears swap_pending, returns to S_VBLANK.
- swap_pending: set when swap_req==1 and swap_ack==0.
- Swaps never occur in S_ACTIVE. A request raised mid-frame is deferred to the next blanking interval.
- At most one swap per frame. A second request arriving in the same blanking interval after the ack waits for the next blanking interval.
- A request coincident with the S_ACTIVE->S_VBLANK transition is honoured in that same blanking.
- swap_req dropping before ack is a capture-side error. swap_pending is not cleared by it.

Decomposition:
- Shared package: H_ACTIVE, V_ACTIVE, IMG_W, IMG_H, PIX_W, frame-buffer ADDR_W, and the FSM state encoding (S_VBLANK=0, S_ACTIVE=1, S_SWAP=2). The timing generator and capture writer use the same constants.
- One natural sub-module: vga_pix_delay. It is a parameterised shift-register delay line (depth 1+RD_LAT) for the visible flag and first-pixel marker.

Test Plan:
- Reset, then hcnt=0,vcnt=0 -> fb_rd_addr=0 next cycle; de_out rises 2+RD_LAT cycles later; frame_start pulses once.
- hcnt=5,vcnt=3 -> fb_rd_addr=1*320+2=322. hcnt=639,vcnt=479 -> 76799.
- BRAM model returns data=addr[11:0] -> rgb_out sequence 0,0,1,1,2,2... on line 0. Lines 0 and 1 are identical. hcnt=640..799 gives rgb_out=0 and de_out=0.
- swap_req raised at vcnt=100 -> no toggle during visible lines. At vcnt=480,hcnt=0 fb_rd_sel toggles 0->1 within 2 cycles and swap_ack pulses exactly one cycle.
- swap_req held after ack through vblank -> no second toggle until the next frame's vcnt=480.
- reset asserted at vcnt=200,hcnt=300 -> next cycle all outputs at reset values and fb_rd_sel=0. Clean restart at the next vcnt=0,hcnt=0.
